// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory copy controller.
// State encoding, default widths and memory read/write flag values.
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 12;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

endpackage

// File: rtl/mem_copy_ctrl.sv
// Block copy master for a single-port register memory: read word, write word, repeat.
// Optional running sum of written words on port checksum when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              mem_reading,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_t            state;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  nxt_idx;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;

    assign nxt_idx = idx + LEN_W'(1);

    // Read data registered at the RD->WR edge is forwarded straight to the write port.
    assign mem_wdata = (state == WR) ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_reading <= MEM_READ;
            mem_address <= '0;
            idx         <= '0;
            len_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state       <= RD;
                            busy        <= 1'b1;
                            mem_address <= src_addr;
                            src_q       <= src_addr;
                            dst_q       <= dst_addr;
                            len_q       <= len;
                            idx         <= '0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state       <= WR;
                    mem_reading <= MEM_WRITE;
                    mem_address <= dst_q + ADDR_W'(idx);
                end
                WR: begin
                    mem_reading <= MEM_READ;
                    if (nxt_idx == len_q) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        mem_address <= '0;
                    end else begin
                        state       <= RD;
                        idx         <= nxt_idx;
                        mem_address <= src_q + ADDR_W'(nxt_idx);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (state == WR) begin
            checksum <= checksum + mem_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Self-checking bench for mem_copy_ctrl with a behavioural memory and copy model.
// Build with MEM_COPY_CHECKSUM_EN defined to also check the checksum port.
module tb_mem_copy_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] src_addr;
    logic [11:0] dst_addr;
    logic [11:0] len;
    logic        busy;
    logic        done;
    logic        mem_reading;
    logic [11:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int n_cmp;
    int n_bad;

    logic [31:0] mem    [4096];
    logic [31:0] refmem [4096];
    logic        init_req;
    int          init_mode;
    logic [31:0] init_seed;

    mem_copy_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .mem_reading(mem_reading),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i, input int mode, input logic [31:0] seed);
        if (mode == 0) return 32'(i);
        return (32'(i) * 32'h9E3779B1) ^ seed;
    endfunction

    // Register memory: writes whenever the reading flag is low, 1-cycle read latency.
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i, init_mode, init_seed);
        end else if (mem_reading == 1'b0) begin
            mem[mem_address] <= mem_wdata;
        end
        mem_rdata <= mem[mem_address];
    end

    task automatic init_mem(input int mode, input logic [31:0] seed);
        @(negedge clk);
        init_mode = mode;
        init_seed = seed;
        init_req  = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        for (int i = 0; i < 4096; i++) refmem[i] = pat(i, mode, seed);
    endtask

    task automatic check_mem(input string tag);
        int bad_idx;
        bad_idx = -1;
        for (int i = 0; i < 4096; i++)
            if (mem[i] !== refmem[i] && bad_idx < 0) bad_idx = i;
        n_cmp++;
        if (bad_idx >= 0) begin
            n_bad++;
            $display("FAIL %s mem[%0d]: got %h want %h", tag, bad_idx,
                     mem[bad_idx], refmem[bad_idx]);
        end
    endtask

    task automatic run_copy(input logic [11:0] s, input logic [11:0] d,
                            input logic [11:0] n, input bit intrude, input string tag);
        logic [11:0] rexp[$];
        logic [11:0] wexp[$];
        logic [31:0] dexp[$];
        logic [11:0] rq[$];
        logic [11:0] wq[$];
        logic [31:0] dq[$];
        logic [31:0] sum;
        int done_cyc, done_cnt, busy_bad, seq_bad, last;
        sum = 0;
        for (int k = 0; k < int'(n); k++) begin
            logic [11:0] ra, wa;
            ra = s + 12'(k);
            wa = d + 12'(k);
            rexp.push_back(ra);
            wexp.push_back(wa);
            dexp.push_back(refmem[ra]);
            sum += refmem[ra];
            refmem[wa] = refmem[ra];
        end
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        @(negedge clk);
        start = 1'b0;
        src_addr = 12'($urandom); dst_addr = 12'($urandom); len = 12'($urandom);
        done_cyc = -1; done_cnt = 0; busy_bad = 0;
        last = 2 * int'(n) + 4;
        for (int c = 1; c <= last; c++) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
`ifdef MEM_COPY_CHECKSUM_EN
                n_cmp++;
                if (checksum !== sum) begin
                    n_bad++;
                    $display("FAIL %s checksum at done: got %0d want %0d", tag, checksum, sum);
                end
`endif
            end
`ifdef MEM_COPY_CHECKSUM_EN
            if (c == 1) begin
                n_cmp++;
                if (checksum !== 32'd0) begin
                    n_bad++;
                    $display("FAIL %s checksum cleared: got %0d want 0", tag, checksum);
                end
            end
`endif
            if (busy !== (c <= 2 * int'(n))) busy_bad++;
            if (mem_reading === 1'b0) begin
                wq.push_back(mem_address);
                dq.push_back(mem_wdata);
            end else if (busy) begin
                rq.push_back(mem_address);
            end
            if (intrude && (c == 3 || c == 2 * int'(n) + 1)) begin
                start = 1'b1; src_addr = 12'd100; dst_addr = 12'd200; len = 12'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (done_cnt != 1 || done_cyc != 2 * int'(n) + 1) begin
            n_bad++;
            $display("FAIL %s done: got %0d pulses first at cycle %0d want 1 at cycle %0d",
                     tag, done_cnt, done_cyc, 2 * int'(n) + 1);
        end
        n_cmp++;
        if (busy_bad != 0) begin
            n_bad++;
            $display("FAIL %s busy window: got %0d bad cycles want 0 (high cycles 1..%0d)",
                     tag, busy_bad, 2 * int'(n));
        end
        seq_bad = 0;
        if (rq.size() != rexp.size()) seq_bad++;
        else foreach (rq[k]) if (rq[k] !== rexp[k]) seq_bad++;
        n_cmp++;
        if (seq_bad != 0) begin
            n_bad++;
            $display("FAIL %s read addrs: got %0d reads (%0d bad) want %0d", tag,
                     rq.size(), seq_bad, rexp.size());
        end
        seq_bad = 0;
        if (wq.size() != wexp.size()) seq_bad++;
        else foreach (wq[k]) if (wq[k] !== wexp[k] || dq[k] !== dexp[k]) seq_bad++;
        n_cmp++;
        if (seq_bad != 0) begin
            n_bad++;
            $display("FAIL %s writes: got %0d writes (%0d bad) want %0d", tag,
                     wq.size(), seq_bad, wexp.size());
        end
        check_mem(tag);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; src_addr = 0; dst_addr = 0; len = 0; init_req = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_reading !== 1'b1 ||
            mem_address !== 12'd0 || mem_wdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset outputs: got busy=%b done=%b rd=%b addr=%h wdata=%h want 0 0 1 0 0",
                     busy, done, mem_reading, mem_address, mem_wdata);
        end
`ifdef MEM_COPY_CHECKSUM_EN
        n_cmp++;
        if (checksum !== 32'd0) begin
            n_bad++;
            $display("FAIL reset checksum: got %0d want 0", checksum);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        init_mem(0, 0);
        run_copy(12'd0, 12'd8, 12'd4, 1'b0, "basic");
    endtask

    task automatic test_zero_len;
        run_copy(12'd0, 12'd8, 12'd0, 1'b0, "zero_len");
    endtask

    task automatic test_back_to_back;
        init_mem(0, 0);
        run_copy(12'd0, 12'd8, 12'd4, 1'b1, "ignored_start");
    endtask

    task automatic test_wrap;
        init_mem(1, 32'h1234_5678);
        run_copy(12'd4094, 12'd10, 12'd3, 1'b0, "wrap");
    endtask

    task automatic test_overlap;
        init_mem(1, 32'hCAFE_0001);
        run_copy(12'd20, 12'd22, 12'd6, 1'b0, "overlap");
    endtask

    task automatic test_reset_mid(input int c_rst);
        int done_seen;
        init_mem(0, 0);
        for (int k = 0; k < 4; k++)
            if (2 * k + 2 < c_rst) refmem[8 + k] = refmem[k];
        done_seen = 0;
        @(negedge clk);
        start = 1'b1; src_addr = 0; dst_addr = 8; len = 4;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < c_rst; c++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (mem_reading !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid%0d immediate: got rd=%b busy=%b want 1 0",
                     c_rst, mem_reading, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_bad++;
            $display("FAIL reset_mid%0d done: got %0d pulses want 0", c_rst, done_seen);
        end
        check_mem($sformatf("reset_mid%0d", c_rst));
    endtask

    task automatic test_random;
        logic [11:0] s, d, n;
        init_mem(1, $urandom);
        for (int t = 0; t < 8; t++) begin
            s = 12'($urandom);
            d = 12'($urandom);
            n = 12'($urandom_range(0, 24));
            if (t % 3 == 0) d = s + 12'($urandom_range(1, 5));
            if (t == 4) s = 12'(4096 - $urandom_range(1, 8));
            run_copy(s, d, n, 1'b0, $sformatf("random%0d", t));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        init_mode = 0;
        init_seed = 0;
        test_reset();
        test_basic();
        test_zero_len();
        test_back_to_back();
        test_wrap();
        test_overlap();
        test_reset_mid(5);
        test_reset_mid(6);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
